// File: rtl/wb_usb_hid_report_fifo_pkg.sv
// ---------------------------------------------------------------------------
// usb_hid_pkg
// Shared constants for the Wishbone HID report FIFO:
//   - register word addresses (REG_CTRL .. REG_MASK)
//   - HID device type encodings (TYP_NONE/KBD/MOUSE/GAME)
//   - entry_w(): width of one FIFO entry for a given report width.
// Optional build macro: HID_TIMESTAMP_EN (adds a 32-bit timestamp per entry).
// ---------------------------------------------------------------------------
package usb_hid_pkg;

  localparam logic [3:0] REG_CTRL    = 4'd0;
  localparam logic [3:0] REG_STATUS  = 4'd1;
  localparam logic [3:0] REG_HEAD    = 4'd2;
  localparam logic [3:0] REG_DATA_LO = 4'd3;
  localparam logic [3:0] REG_DATA_HI = 4'd4;
  localparam logic [3:0] REG_POP     = 4'd5;
  localparam logic [3:0] REG_TSTAMP  = 4'd6;
  localparam logic [3:0] REG_MASK    = 4'd7;

  localparam logic [1:0] TYP_NONE  = 2'd0;
  localparam logic [1:0] TYP_KBD   = 2'd1;
  localparam logic [1:0] TYP_MOUSE = 2'd2;
  localparam logic [1:0] TYP_GAME  = 2'd3;

  localparam int TS_W = 32;

  // Entry layout (LSB first): data[REPORT_W], typ[2], conerr[1], optional timestamp[32].
  function automatic int entry_w(input int report_w);
`ifdef HID_TIMESTAMP_EN
    return report_w + 3 + TS_W;
`else
    return report_w + 3;
`endif
  endfunction

endpackage

// File: rtl/wb_usb_hid_report_fifo_mem.sv
// ---------------------------------------------------------------------------
// hid_report_fifo_mem
// Entry storage for the HID report FIFO: RAM, read/write pointers, level,
// full/empty flags and the overwrite-oldest path. Head entry is presented
// combinationally (zero when empty).
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i             write wdata_i this cycle (already filtered by type)
//   pop_i              drop head entry (ignored when empty)
//   flush_i            empty the FIFO; overrides push and pop
//   drop_i             full policy: 1 discard newest, 0 overwrite oldest
//   wdata_i            entry to write
//   head_o             head entry, 0 when empty
//   level_o            entry count 0..DEPTH
//   full_o, empty_o    status flags
//   ovf_o              one-cycle pulse: a push met a full FIFO
// ---------------------------------------------------------------------------
module hid_report_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int EW    = 67
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic                   drop_i,
  input  logic [EW-1:0]          wdata_i,
  output logic [EW-1:0]          head_o,
  output logic [$clog2(DEPTH):0] level_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   ovf_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_s, empty_s, do_pop_s, do_wr_s, ovf_s;

  // Next-state for pointers and level, including the full-FIFO policies.
  always_comb begin
    full_s   = (level_q == LW'(DEPTH));
    empty_s  = (level_q == {LW{1'b0}});
    do_pop_s = pop_i & ~empty_s & ~flush_i;
    // A full FIFO still accepts the write if the head leaves this cycle or
    // the policy is overwrite-oldest.
    do_wr_s  = push_i & ~flush_i & (~full_s | do_pop_s | ~drop_i);
    ovf_s    = push_i & ~flush_i & full_s & ~do_pop_s;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = {LW{1'b0}};
    end else begin
      if (do_wr_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      // Overwrite-oldest on a full FIFO advances the read side as well.
      if (do_pop_s || (do_wr_s && full_s)) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      if (do_wr_s && !do_pop_s && !full_s) begin
        level_d = level_q + LW'(1);
      end else if (do_pop_s && !do_wr_s) begin
        level_d = level_q - LW'(1);
      end else begin
        level_d = level_q;
      end
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      level_q  <= {LW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry RAM write port; contents need no reset since level gates reads.
  always_ff @(posedge clk_i) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign head_o  = empty_s ? {EW{1'b0}} : mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = full_s;
  assign empty_o = empty_s;
  assign ovf_o   = ovf_s;

endmodule

// File: rtl/wb_usb_hid_report_fifo.sv
// ---------------------------------------------------------------------------
// wb_usb_hid_report_fifo
// Wishbone-visible queue of HID reports. Each accepted report becomes one
// entry {conerr, typ, report}; software reads the head via HEAD/DATA_LO/
// DATA_HI(/TSTAMP) and removes it by writing POP. Provides a per-type accept
// mask, a level-threshold IRQ, drop-newest/overwrite-oldest policy and a
// saturating overflow counter.
// Optional build macro: HID_TIMESTAMP_EN -- free-running 32-bit counter whose
// value is stored with each entry and returned by TSTAMP (0 otherwise).
// Ports:
//   wb_clk, sys_rst_n        clock, asynchronous active-low reset
//   rpt_stb_i/typ/conerr/data report input, one-cycle strobe
//   wbs_*                    pipelined Wishbone slave (stall/err tied 0)
//   irq                      level IRQ: ien && level >= max(thresh,1)
// ---------------------------------------------------------------------------
module wb_usb_hid_report_fifo
  import usb_hid_pkg::*;
#(
  parameter int DEPTH      = 8,
  parameter int REPORT_W   = 64,
  parameter int THRESH_RST = 1
) (
  input  logic                wb_clk,
  input  logic                sys_rst_n,
  input  logic                rpt_stb_i,
  input  logic [1:0]          rpt_typ_i,
  input  logic                rpt_conerr_i,
  input  logic [REPORT_W-1:0] rpt_data_i,
  input  logic [3:0]          wbs_adr,
  input  logic [31:0]         wbs_dat_w,
  output logic [31:0]         wbs_dat_r,
  input  logic [3:0]          wbs_sel,
  input  logic                wbs_cyc,
  input  logic                wbs_stb,
  input  logic                wbs_we,
  output logic                wbs_ack,
  output logic                wbs_stall,
  output logic                wbs_err,
  output logic                irq
);

  localparam int EW = entry_w(REPORT_W);
  localparam int LW = $clog2(DEPTH) + 1;
  // Every type except "none" is accepted out of reset.
  localparam logic [3:0] MASK_RST = ~(4'b0001 << TYP_NONE);

  logic             ack_q, ack_d;
  logic             ien_q, ien_d;
  logic             drop_q, drop_d;
  logic [7:0]       thresh_q, thresh_d;
  logic [3:0]       mask_q, mask_d;
  logic [7:0]       ovf_q, ovf_d;

  logic             wr_en_s, ctrl_wr_s, flush_s, status_wr_s, pop_s, mask_wr_s;
  logic             push_s, ovf_evt_s, full_s, empty_s, irq_s;
  logic [LW-1:0]    level_s;
  logic [EW-1:0]    wr_entry_s, head_entry_s;
  logic [63:0]      head_data_s;
  logic [31:0]      head_ts_s;
  logic [7:0]       thresh_eff_s;
  logic             unused_s;

  assign wr_en_s     = wbs_cyc & wbs_stb & wbs_we;
  assign ctrl_wr_s   = wr_en_s & (wbs_adr == REG_CTRL);
  assign flush_s     = ctrl_wr_s & wbs_dat_w[31];
  assign status_wr_s = wr_en_s & (wbs_adr == REG_STATUS);
  assign pop_s       = wr_en_s & (wbs_adr == REG_POP);
  assign mask_wr_s   = wr_en_s & (wbs_adr == REG_MASK);
  assign push_s      = rpt_stb_i & mask_q[rpt_typ_i];

`ifdef HID_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running timestamp counter, wraps naturally.
  always_ff @(posedge wb_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ts_q <= 32'd0;
    end else begin
      ts_q <= ts_q + 32'd1;
    end
  end

  assign wr_entry_s = {ts_q, rpt_conerr_i, rpt_typ_i, rpt_data_i};
  assign head_ts_s  = head_entry_s[EW-1 -: TS_W];
`else
  assign wr_entry_s = {rpt_conerr_i, rpt_typ_i, rpt_data_i};
  assign head_ts_s  = 32'd0;
`endif

  hid_report_fifo_mem #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_mem (
    .clk_i   (wb_clk),
    .rst_ni  (sys_rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .drop_i  (drop_q),
    .wdata_i (wr_entry_s),
    .head_o  (head_entry_s),
    .level_o (level_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .ovf_o   (ovf_evt_s)
  );

  assign head_data_s  = 64'(head_entry_s[REPORT_W-1:0]);
  assign thresh_eff_s = (thresh_q == 8'd0) ? 8'd1 : thresh_q;
  assign irq_s        = ien_q & (8'(level_s) >= thresh_eff_s);

  // Next-state for control registers, overflow counter and ack.
  always_comb begin
    ack_d    = wbs_stb;
    ien_d    = ien_q;
    drop_d   = drop_q;
    thresh_d = thresh_q;
    mask_d   = mask_q;
    ovf_d    = ovf_q;
    if (ctrl_wr_s) begin
      ien_d    = wbs_dat_w[0];
      drop_d   = wbs_dat_w[1];
      thresh_d = wbs_dat_w[15:8];
    end else begin
      ien_d    = ien_q;
      drop_d   = drop_q;
      thresh_d = thresh_q;
    end
    if (mask_wr_s) begin
      mask_d = wbs_dat_w[3:0];
    end else begin
      mask_d = mask_q;
    end
    // A clear that coincides with an overflow leaves exactly that one counted.
    if (status_wr_s) begin
      ovf_d = ovf_evt_s ? 8'd1 : 8'd0;
    end else if (ovf_evt_s && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 8'd1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Register state.
  always_ff @(posedge wb_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ack_q    <= 1'b0;
      ien_q    <= 1'b0;
      drop_q   <= 1'b0;
      thresh_q <= 8'(THRESH_RST);
      mask_q   <= MASK_RST;
      ovf_q    <= 8'd0;
    end else begin
      ack_q    <= ack_d;
      ien_q    <= ien_d;
      drop_q   <= drop_d;
      thresh_q <= thresh_d;
      mask_q   <= mask_d;
      ovf_q    <= ovf_d;
    end
  end

  // Read mux, combinational from the address.
  always_comb begin
    wbs_dat_r = 32'd0;
    case (wbs_adr)
      REG_CTRL:    wbs_dat_r = {16'd0, thresh_q, 6'd0, drop_q, ien_q};
      REG_STATUS:  wbs_dat_r = {8'd0, ovf_q, 8'(level_s), 5'd0, full_s, empty_s, irq_s};
      REG_HEAD:    wbs_dat_r = {29'd0, head_entry_s[REPORT_W+2:REPORT_W]};
      REG_DATA_LO: wbs_dat_r = head_data_s[31:0];
      REG_DATA_HI: wbs_dat_r = head_data_s[63:32];
      REG_TSTAMP:  wbs_dat_r = head_ts_s;
      REG_MASK:    wbs_dat_r = {28'd0, mask_q};
      default:     wbs_dat_r = 32'd0;
    endcase
  end

  assign wbs_ack   = ack_q & wbs_cyc;
  assign wbs_stall = 1'b0;
  assign wbs_err   = 1'b0;
  assign irq       = irq_s;
  assign unused_s  = ^{wbs_sel, wbs_dat_w};

endmodule
